// File: rtl/fp_mult_responder_if.sv
// Start/ready channel between the term accumulator (master) and an FP multiply responder (slave).
// Latency: none, wires only.
// Backpressure: none; the master must watch busy, and starts issued while busy are dropped.
// Signals: mult_start, operand_a, operand_b (master->slave); mult_result, mult_data_ready, busy (slave->master).
interface fp_mult_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mult_start;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] mult_result;
    logic                  mult_data_ready;
    logic                  busy;

    modport master (
        output mult_start,
        output operand_a,
        output operand_b,
        input  mult_result,
        input  mult_data_ready,
        input  busy
    );

    modport slave (
        input  mult_start,
        input  operand_a,
        input  operand_b,
        output mult_result,
        output mult_data_ready,
        output busy
    );
endinterface

// File: rtl/fp_mult_responder.sv
// IEEE-754 multiply responder on the ALU start/ready channel; denormals flush to zero, RNE rounding.
// Latency: start sampled at edge N, ready pulse in the 5th cycle after N; one op per 6 cycles.
// Backpressure: none; mult_start while busy or in DONE is ignored, result is zero unless ready (OR-bus).
// Ports: clock, reset (async, active-high), mult_bus (slave modport of fp_mult_responder_if).
module fp_mult_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic               clock,
    input  logic               reset,
    fp_mult_responder_if.slave mult_bus
);
    localparam int M  = MANTISSA_LEN;
    localparam int EW = EXP_LEN + 2;
    localparam int PW = 2 * (M + 1);

    localparam logic signed [EW-1:0]  BIAS    = EW'((1 << (EXP_LEN - 1)) - 1);
    localparam logic signed [EW-1:0]  EXP_MAX = EW'((1 << EXP_LEN) - 1);
    localparam logic signed [EW-1:0]  EXP_ONE = EW'(1);
    localparam logic [DATA_WIDTH-1:0] QNAN    = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(M-1){1'b0}}};

    if (DATA_WIDTH != 1 + EXP_LEN + MANTISSA_LEN) begin : g_width_check
        $error("fp_mult_responder: DATA_WIDTH must equal 1+EXP_LEN+MANTISSA_LEN");
    end

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state_q, state_d;

    // captured operands
    logic [DATA_WIDTH-1:0] op_a, op_b;

    // UNPACK stage
    logic                  u_sa, u_sb;
    logic [EXP_LEN-1:0]    u_ea, u_eb;
    logic [M:0]            u_ma, u_mb;
    logic                  a_zero, a_inf, a_nan;
    logic                  b_zero, b_inf, b_nan;

    // MULT stage
    logic [PW-1:0]         p_prod;
    logic signed [EW-1:0]  p_exp;
    logic                  p_sign;

    // NORM stage
    logic [M:0]            n_mant;
    logic                  n_guard, n_round, n_sticky;
    logic signed [EW-1:0]  n_exp;

    // packed result presented in DONE
    logic [DATA_WIDTH-1:0] res_q;

    // field views of the captured operands
    logic [EXP_LEN-1:0]    a_exp_w, b_exp_w;
    logic [M-1:0]          a_frac_w, b_frac_w;

    assign a_exp_w  = op_a[M +: EXP_LEN];
    assign b_exp_w  = op_b[M +: EXP_LEN];
    assign a_frac_w = op_a[M-1:0];
    assign b_frac_w = op_b[M-1:0];

    // Normalisation: the product of two 1.f values lies in [1,4). When it reaches 2 the
    // word drops one position and the bit shifted out must still reach sticky.
    logic                  norm_shift;
    logic [PW-2:0]         norm_bits;
    logic                  norm_extra;

    assign norm_shift = p_prod[PW-1];
    assign norm_bits  = norm_shift ? p_prod[PW-1:1] : p_prod[PW-2:0];
    assign norm_extra = norm_shift & p_prod[0];

    // Rounding and special-case resolution, registered on the ROUND -> DONE edge.
    logic                  r_inc;
    logic [M+1:0]          r_sum;
    logic [M-1:0]          r_frac;
    logic signed [EW-1:0]  r_exp;
    logic                  r_nan, r_inf, r_zero;
    logic [DATA_WIDTH-1:0] round_res;

    always_comb begin
        r_inc  = n_guard & (n_round | n_sticky | n_mant[0]);
        r_sum  = {1'b0, n_mant} + {{(M+1){1'b0}}, r_inc};
        // carry out of the mantissa means it rounded up to exactly 2.0
        r_frac = r_sum[M+1] ? r_sum[M:1] : r_sum[M-1:0];
        r_exp  = r_sum[M+1] ? n_exp + EXP_ONE : n_exp;

        r_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        r_inf  = a_inf | b_inf;
        r_zero = a_zero | b_zero;

        if (r_nan) begin
            round_res = QNAN;
        end else if (r_inf) begin
            round_res = {p_sign, {EXP_LEN{1'b1}}, {M{1'b0}}};
        end else if (r_zero) begin
            round_res = {p_sign, {(DATA_WIDTH-1){1'b0}}};
        end else if (r_exp >= EXP_MAX) begin
            round_res = {p_sign, {EXP_LEN{1'b1}}, {M{1'b0}}};
        end else if (r_exp[EW-1] || (r_exp == '0)) begin
            round_res = {p_sign, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            round_res = {p_sign, r_exp[EXP_LEN-1:0], r_frac};
        end
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and outputs
    always_comb begin
        state_d                  = state_q;
        mult_bus.busy            = 1'b0;
        mult_bus.mult_data_ready = 1'b0;
        mult_bus.mult_result     = '0;
        case (state_q)
            IDLE: begin
                if (mult_bus.mult_start) begin
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                state_d       = MULT;
                mult_bus.busy = 1'b1;
            end
            MULT: begin
                state_d       = NORM;
                mult_bus.busy = 1'b1;
            end
            NORM: begin
                state_d       = ROUND;
                mult_bus.busy = 1'b1;
            end
            ROUND: begin
                state_d       = DONE;
                mult_bus.busy = 1'b1;
            end
            DONE: begin
                state_d                  = IDLE;
                mult_bus.busy            = 1'b1;
                mult_bus.mult_data_ready = 1'b1;
                mult_bus.mult_result     = res_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // datapath: each stage register loads only in its own state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            u_sa     <= 1'b0;
            u_sb     <= 1'b0;
            u_ea     <= '0;
            u_eb     <= '0;
            u_ma     <= '0;
            u_mb     <= '0;
            a_zero   <= 1'b0;
            a_inf    <= 1'b0;
            a_nan    <= 1'b0;
            b_zero   <= 1'b0;
            b_inf    <= 1'b0;
            b_nan    <= 1'b0;
            p_prod   <= '0;
            p_exp    <= '0;
            p_sign   <= 1'b0;
            n_mant   <= '0;
            n_guard  <= 1'b0;
            n_round  <= 1'b0;
            n_sticky <= 1'b0;
            n_exp    <= '0;
            res_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mult_bus.mult_start) begin
                        op_a <= mult_bus.operand_a;
                        op_b <= mult_bus.operand_b;
                    end
                end
                UNPACK: begin
                    u_sa   <= op_a[DATA_WIDTH-1];
                    u_sb   <= op_b[DATA_WIDTH-1];
                    u_ea   <= a_exp_w;
                    u_eb   <= b_exp_w;
                    // exp==0 covers denormals, which are treated as zero
                    u_ma   <= (a_exp_w == '0) ? '0 : {1'b1, a_frac_w};
                    u_mb   <= (b_exp_w == '0) ? '0 : {1'b1, b_frac_w};
                    a_zero <= (a_exp_w == '0);
                    b_zero <= (b_exp_w == '0);
                    a_inf  <= (a_exp_w == '1) && (a_frac_w == '0);
                    b_inf  <= (b_exp_w == '1) && (b_frac_w == '0);
                    a_nan  <= (a_exp_w == '1) && (a_frac_w != '0);
                    b_nan  <= (b_exp_w == '1) && (b_frac_w != '0);
                end
                MULT: begin
                    p_prod <= PW'(u_ma) * PW'(u_mb);
                    p_exp  <= $signed({2'b00, u_ea}) + $signed({2'b00, u_eb}) - BIAS;
                    p_sign <= u_sa ^ u_sb;
                end
                NORM: begin
                    n_mant   <= norm_bits[2*M:M];
                    n_guard  <= norm_bits[M-1];
                    n_round  <= norm_bits[M-2];
                    n_sticky <= (|norm_bits[M-3:0]) | norm_extra;
                    n_exp    <= norm_shift ? p_exp + EXP_ONE : p_exp;
                end
                ROUND: begin
                    res_q <= round_res;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mult_responder.sv
// Directed bench for fp_mult_responder with a result scoreboard and an OR-bus monitor.
// Latency: expects the ready pulse in the 5th cycle after the sampling edge, one op per 6 cycles when start is held.
// Backpressure: checks that starts issued while busy are dropped and that reset discards an in-flight op.
module tb_fp_mult_responder;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    fp_mult_responder_if #(.DATA_WIDTH(32)) bus ();

    fp_mult_responder #(
        .DATA_WIDTH  (32),
        .EXP_LEN     (8),
        .MANTISSA_LEN(23)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .mult_bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard/monitor: every ready pulse must match the oldest expected result,
    // and the result bus must be zero on every other cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.mult_data_ready) begin
                if (exp_q.size() > 0) begin
                    check("result", bus.mult_result, exp_q.pop_front());
                end else begin
                    check("spurious_ready", {31'b0, bus.mult_data_ready}, 32'd0);
                end
            end else begin
                check("orbus_zero", bus.mult_result, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int cyc;
        @(negedge clock);
        bus.mult_start = 1'b1;
        bus.operand_a  = a;
        bus.operand_b  = b;
        exp_q.push_back(expv);
        @(posedge clock);
        #1;
        bus.mult_start = 1'b0;
        bus.operand_a  = $urandom;
        bus.operand_b  = $urandom;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
            if (bus.mult_data_ready) break;
        end
        check("ready_latency", cyc, 32'd5);
        @(negedge clock);
        check("busy_after_done", {31'b0, bus.busy}, 32'd0);
    endtask

    logic [31:0] vec_a [8] = '{32'h40400000, 32'h3F800001, 32'h7F000000, 32'h7F800000,
                               32'h7FC00001, 32'h00800000, 32'h80000000, 32'h00000001};
    logic [31:0] vec_b [8] = '{32'hBF000000, 32'h3F800001, 32'h7F000000, 32'h00000000,
                               32'h3F800000, 32'h00800000, 32'h3F800000, 32'h7F000000};
    logic [31:0] vec_r [8] = '{32'hBFC00000, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
                               32'h7FC00000, 32'h00000000, 32'h80000000, 32'h00000000};

    initial begin
        int pulses;
        int pulse_at[$];

        reset          = 1'b1;
        bus.mult_start = 1'b0;
        bus.operand_a  = '0;
        bus.operand_b  = '0;
        #12;
        check("reset_ready",  {31'b0, bus.mult_data_ready}, 32'd0);
        check("reset_result", bus.mult_result, 32'd0);
        check("reset_busy",   {31'b0, bus.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // normal product 1.5 x 2.0
        run_op(32'h3FC00000, 32'h40000000, 32'h40400000);

        // sign, rounding, overflow, NaN, underflow, signed zero, denormal flush
        for (int i = 0; i < 8; i++) begin
            run_op(vec_a[i], vec_b[i], vec_r[i]);
        end

        // a start issued while busy must be dropped
        @(negedge clock);
        bus.mult_start = 1'b1;
        bus.operand_a  = 32'h3FC00000;
        bus.operand_b  = 32'h40000000;
        exp_q.push_back(32'h40400000);
        @(posedge clock);
        #1;
        bus.mult_start = 1'b0;
        @(negedge clock);
        bus.mult_start = 1'b1;
        bus.operand_a  = 32'h40800000;
        bus.operand_b  = 32'h40800000;
        @(negedge clock);
        bus.mult_start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (bus.mult_data_ready) pulses++;
        end
        check("busy_ignore_pulses", pulses, 32'd1);

        // start held high: accepts at edges 0, 6, 12 -> pulses after edges 4, 10, 16
        repeat (3) exp_q.push_back(32'h40400000);
        @(negedge clock);
        bus.mult_start = 1'b1;
        bus.operand_a  = 32'h3FC00000;
        bus.operand_b  = 32'h40000000;
        for (int c = 0; c < 25; c++) begin
            @(posedge clock);
            if (c == 12) begin
                #1;
                bus.mult_start = 1'b0;
            end
            @(negedge clock);
            if (bus.mult_data_ready) pulse_at.push_back(c);
        end
        check("hold_pulse_count", pulse_at.size(), 32'd3);
        if (pulse_at.size() == 3) begin
            check("hold_first_pulse", pulse_at[0], 32'd4);
            check("hold_gap_1", pulse_at[1] - pulse_at[0], 32'd6);
            check("hold_gap_2", pulse_at[2] - pulse_at[1], 32'd6);
        end

        // asynchronous reset while in MULT discards the operation
        @(negedge clock);
        bus.mult_start = 1'b1;
        bus.operand_a  = 32'h3FC00000;
        bus.operand_b  = 32'h40000000;
        @(posedge clock);
        #1;
        bus.mult_start = 1'b0;
        @(posedge clock);
        #3;
        check("busy_in_mult", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_busy",   {31'b0, bus.busy}, 32'd0);
        check("arst_ready",  {31'b0, bus.mult_data_ready}, 32'd0);
        check("arst_result", bus.mult_result, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (bus.mult_data_ready) pulses++;
        end
        check("no_pulse_after_reset", pulses, 32'd0);

        run_op(32'h3FC00000, 32'h40000000, 32'h40400000);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
